// File: rtl/disp_bcd_digit_driver_if.sv
// disp_bcd_digit_driver_if: valid/ready channel carrying the binary value to display.
interface disp_bcd_digit_driver_if #(
    parameter int DATA_W = 14
);
    logic [DATA_W-1:0] bin_in;
    logic              bin_valid;
    logic              bin_ready;
    modport master (output bin_in, output bin_valid, input bin_ready);
    modport slave  (input bin_in, input bin_valid, output bin_ready);
endinterface

// File: rtl/disp_bcd_digit_driver.sv
// disp_bcd_digit_driver: binary-to-BCD converter plus 7-segment driver for a 4-digit anode scanner.
module disp_bcd_digit_driver #(
    parameter int DATA_W         = 14,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit BLANK_LZ       = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    disp_bcd_digit_driver_if.slave        bus,
    input  logic [3:0]                    a,
    output logic [6:0]                    seg,
    output logic                          upd
);
    localparam int         CNT_W   = $clog2(DATA_W + 1);
    localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t            state, state_nx;
    logic [DATA_W-1:0] sh;
    logic [15:0]       bcd, bcd_adj, disp;
    logic [CNT_W-1:0]  cnt;
    logic              ovf_pend, ovf, hs, ovf_in, onehot;
    logic [1:0]        idx;
    logic [3:0]        digit, lz;
    logic [6:0]        raw;

    function automatic logic [6:0] dec(input logic [3:0] d);
        case (d)
            4'd0: return 7'h3F;
            4'd1: return 7'h06;
            4'd2: return 7'h5B;
            4'd3: return 7'h4F;
            4'd4: return 7'h66;
            4'd5: return 7'h6D;
            4'd6: return 7'h7D;
            4'd7: return 7'h07;
            4'd8: return 7'h7F;
            4'd9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    assign bus.bin_ready = state == IDLE;
    assign hs            = bus.bin_valid && bus.bin_ready;
    assign ovf_in        = 32'(bus.bin_in) > 32'd9999;

    always_comb begin
        state_nx = state;
        if (state == IDLE && hs) state_nx = ovf_in ? DONE : SHIFT;
        else if (state == SHIFT && cnt == CNT_W'(DATA_W - 1)) state_nx = DONE;
        else if (state == DONE) state_nx = IDLE;
    end

    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 4; i++)
            bcd_adj[4*i +: 4] = bcd[4*i +: 4] >= 4'd5 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
    end

    // lz[i]: digit i and every digit above it are zero; units is never blanked
    always_comb begin
        onehot = a == 4'b0001 || a == 4'b0010 || a == 4'b0100 || a == 4'b1000;
        idx    = a[1] ? 2'd1 : a[2] ? 2'd2 : a[3] ? 2'd3 : 2'd0;
        digit  = disp[4*idx +: 4];
        lz[3]  = disp[15:12] == 4'd0;
        lz[2]  = lz[3] && disp[11:8] == 4'd0;
        lz[1]  = lz[2] && disp[7:4] == 4'd0;
        lz[0]  = 1'b0;
        raw    = !onehot ? 7'h00 : ovf ? 7'h40 : (BLANK_LZ && lz[idx]) ? 7'h00 : dec(digit);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            sh       <= '0;
            bcd      <= '0;
            cnt      <= '0;
            ovf_pend <= 1'b0;
            disp     <= '0;
            ovf      <= 1'b0;
            upd      <= 1'b0;
            seg      <= SEG_OFF;
        end else begin
            state <= state_nx;
            upd   <= state == DONE;
            seg   <= SEG_ACTIVE_LOW ? ~raw : raw;
            if (hs) begin
                sh       <= bus.bin_in;
                bcd      <= '0;
                cnt      <= '0;
                ovf_pend <= ovf_in;
            end else if (state == SHIFT) begin
                {bcd, sh} <= {bcd_adj[14:0], sh, 1'b0};
                cnt       <= cnt + 1'b1;
            end
            if (state == DONE) begin
                disp <= bcd;
                ovf  <= ovf_pend;
            end
        end
    end
endmodule

// File: tb/tb_disp_bcd_digit_driver.sv
// tb_disp_bcd_digit_driver: directed scoreboard bench; one DUT with defaults, one active-high without blanking.
module tb_disp_bcd_digit_driver;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] a = 4'b0000;
    logic [6:0] seg, seg2;
    logic       upd, upd2;
    int         cyc = 0, checks = 0, failures = 0, upd_pops = 0;

    typedef struct {
        int         due;
        logic [6:0] e1;
        logic [6:0] e2;
        string      nm;
    } seg_t;
    int   updq[$];
    seg_t segq[$];

    disp_bcd_digit_driver_if #(.DATA_W(14)) bif ();
    disp_bcd_digit_driver_if #(.DATA_W(14)) bif2 ();
    assign bif2.bin_in    = bif.bin_in;
    assign bif2.bin_valid = bif.bin_valid;

    disp_bcd_digit_driver dut (.clk(clk), .rst_n(rst_n), .bus(bif.slave), .a(a), .seg(seg), .upd(upd));
    disp_bcd_digit_driver #(.DATA_W(14), .SEG_ACTIVE_LOW(1'b0), .BLANK_LZ(1'b0)) dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bif2.slave), .a(a), .seg(seg2), .upd(upd2));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: upd pulses and registered segment outputs are checked against queued expectations
    always @(negedge clk) begin
        seg_t s;
        if (rst_n && upd) begin
            if (updq.size() == 0) chk("unexpected_upd", 1, 0);
            else begin
                chk("upd_cycle", cyc, updq.pop_front());
                chk("upd2_with_upd", int'(upd2), 1);
                chk("ready_at_upd", int'(bif.bin_ready), 1);
                upd_pops++;
            end
        end
        if (segq.size() != 0 && segq[0].due == cyc) begin
            s = segq.pop_front();
            chk({s.nm, "_seg"}, int'(seg), int'(s.e1));
            chk({s.nm, "_seg2"}, int'(seg2), int'(s.e2));
        end
    end

    task automatic seta(input logic [3:0] av, input logic [6:0] e1, input logic [6:0] e2, input string nm);
        @(negedge clk);
        a = av;
        segq.push_back('{cyc + 1, e1, e2, nm});
        @(negedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int k = 0;
        @(negedge clk);
        while (!bif.bin_ready && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!bif.bin_ready) chk("ready_timeout", 0, 1);
    endtask

    task automatic send(input int v, input bit ov);
        int lows = 0;
        wait_ready();
        bif.bin_in    = 14'(v);
        bif.bin_valid = 1'b1;
        updq.push_back(cyc + 1 + (ov ? 1 : 15));
        @(posedge clk);
        #1 bif.bin_valid = 1'b0;
        @(negedge clk);
        while (!bif.bin_ready && lows < 100) begin
            lows++;
            @(negedge clk);
        end
        chk("ready_low_cycles", lows, ov ? 1 : 15);
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((updq.size() != 0 || !bif.bin_ready) && k < 200) begin
            @(negedge clk);
            #2;
            k++;
        end
        if (updq.size() != 0) chk("idle_timeout", int'(updq.size()), 0);
    endtask

    initial begin
        int base, k, e0;
        bif.bin_in    = '0;
        bif.bin_valid = 1'b0;
        a             = 4'b0001;
        #12;
        chk("rst_seg_off", int'(seg), 'h7F);
        chk("rst_seg2_off", int'(seg2), 'h00);
        chk("rst_upd", int'(upd), 0);
        chk("rst_ready", int'(bif.bin_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        seta(4'b0001, 7'h40, 7'h3F, "rst_units");
        seta(4'b0010, 7'h7F, 7'h3F, "rst_tens");
        seta(4'b0100, 7'h7F, 7'h3F, "rst_hund");
        seta(4'b1000, 7'h7F, 7'h3F, "rst_thou");

        send(1234, 1'b0);
        wait_idle();
        seta(4'b0001, 7'h19, 7'h66, "v1234_units");
        seta(4'b0010, 7'h30, 7'h4F, "v1234_tens");
        seta(4'b0100, 7'h24, 7'h5B, "v1234_hund");
        seta(4'b1000, 7'h79, 7'h06, "v1234_thou");
        seta(4'b0000, 7'h7F, 7'h00, "v1234_a0000");

        send(7, 1'b0);
        wait_idle();
        seta(4'b0001, 7'h78, 7'h07, "v7_units");
        seta(4'b0010, 7'h7F, 7'h3F, "v7_tens");
        seta(4'b0100, 7'h7F, 7'h3F, "v7_hund");
        seta(4'b1000, 7'h7F, 7'h3F, "v7_thou");

        send(10000, 1'b1);
        wait_idle();
        seta(4'b0001, 7'h3F, 7'h40, "ovf_units");
        seta(4'b0010, 7'h3F, 7'h40, "ovf_tens");
        seta(4'b0100, 7'h3F, 7'h40, "ovf_hund");
        seta(4'b1000, 7'h3F, 7'h40, "ovf_thou");
        seta(4'b1100, 7'h7F, 7'h00, "ovf_a1100");

        send(9999, 1'b0);
        wait_idle();
        seta(4'b0001, 7'h10, 7'h6F, "v9999_units");
        seta(4'b1000, 7'h10, 7'h6F, "v9999_thou");

        // valid stays high through the 5678 conversion; 42 must wait for the next IDLE
        wait_ready();
        bif.bin_in    = 14'd5678;
        bif.bin_valid = 1'b1;
        e0 = cyc + 1;
        updq.push_back(e0 + 15);
        updq.push_back(e0 + 31);
        @(posedge clk);
        #1 bif.bin_in = 14'd42;
        base = upd_pops;
        k = 0;
        while (upd_pops == base && k < 100) begin
            @(negedge clk);
            #2;
            k++;
        end
        @(posedge clk);
        #1 bif.bin_valid = 1'b0;
        seta(4'b0001, 7'h00, 7'h7F, "hold5678_units");
        seta(4'b1000, 7'h12, 7'h6D, "hold5678_thou");
        wait_idle();
        seta(4'b0001, 7'h24, 7'h5B, "v42_units");
        seta(4'b0010, 7'h19, 7'h66, "v42_tens");
        seta(4'b0100, 7'h7F, 7'h3F, "v42_hund");

        // reset in the middle of converting 8888: no upd, display back to zero
        wait_ready();
        bif.bin_in    = 14'd8888;
        bif.bin_valid = 1'b1;
        @(posedge clk);
        #1 bif.bin_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_seg_off", int'(seg), 'h7F);
        chk("midrst_seg2_off", int'(seg2), 'h00);
        chk("midrst_ready", int'(bif.bin_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        seta(4'b0001, 7'h40, 7'h3F, "midrst_units");
        seta(4'b0010, 7'h7F, 7'h3F, "midrst_tens");
        seta(4'b0110, 7'h7F, 7'h00, "midrst_a0110");
        repeat (30) @(negedge clk);
        chk("segq_drained", int'(segq.size()), 0);
        chk("updq_drained", int'(updq.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
